// File: rtl/dma_addr_gen.sv
// -----------------------------------------------------------------------------
// dma_addr_gen -- DMA address / word-count generator
//
// Holds a 3-bit control register (CR), an address base (AR), an address
// counter (AC), a word reload value (WR) and a word counter (WC). A 3-bit
// instruction arrives every cycle and either loads registers, reads a value
// back on dout, or (ENCT) advances the counters by one step.
//
// CR[1:0] mode:  00 count WC down to 0
//                01 count WC up from 0 to WR
//                10 run AC until it equals WR (WC frozen)
//                11 free-running, never done
// CR[2]      :   address direction, 0 = increment, 1 = decrement
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   instr  in   3      instruction
//   din    in   WIDTH  load data for CR / AR+AC / WR+WC
//   aci    in   1      count enable for ENCT
//   dout   out  WIDTH  registered read-back data
//   oe     out  1      registered "dout is valid"
//   addr   out  WIDTH  current address counter (AC)
//   done   out  1      terminal condition for the current mode
//   aco    out  1      address counter wrap in this step cycle
//   wco    out  1      word counter wrap in this step cycle (mode 11)
//
// Parameter WIDTH: legal range 4..32.
// Optional feature macro: DMA_CARRY_OUT_EN -- when defined, aco/wco report
// counter wrap; when undefined they are tied low.
// -----------------------------------------------------------------------------
module dma_addr_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       instr,
  input  logic [WIDTH-1:0] din,
  input  logic             aci,
  output logic [WIDTH-1:0] dout,
  output logic             oe,
  output logic [WIDTH-1:0] addr,
  output logic             done,
  output logic             aco,
  output logic             wco
);

  typedef enum logic [2:0] {
    I_WRCR   = 3'b000,
    I_RDCR   = 3'b001,
    I_RDWC   = 3'b010,
    I_RDAC   = 3'b011,
    I_REINIT = 3'b100,
    I_LDAR   = 3'b101,
    I_LDWC   = 3'b110,
    I_ENCT   = 3'b111
  } instr_e;

  typedef enum logic [1:0] {
    M_WC_DOWN = 2'b00,
    M_WC_UP   = 2'b01,
    M_AC_CMP  = 2'b10,
    M_FREE    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // State registers and their next-state values
  logic [2:0]       cr_q, cr_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [WIDTH-1:0] wc_q, wc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             oe_q, oe_d;

  mode_e            mode;
  logic             dir_down;
  logic             done_c;
  logic             step;
  logic [WIDTH-1:0] ac_step;
  logic [WIDTH-1:0] wc_step;

  assign mode     = mode_e'(cr_q[1:0]);
  assign dir_down = cr_q[2];

  // Terminal condition is purely a function of registered state, so it
  // tracks a mode change from WRCR in the very next cycle without touching
  // the counters.
  always_comb begin
    done_c = 1'b0;
    case (mode)
      M_WC_DOWN: done_c = (wc_q == '0);
      M_WC_UP:   done_c = (wc_q == wr_q);
      M_AC_CMP:  done_c = (ac_q == wr_q);
      M_FREE:    done_c = 1'b0;
      default:   done_c = 1'b0;
    endcase
  end

  // Stepping is gated by done so the counters stop on exactly the update
  // that satisfied the condition -- no overshoot.
  assign step = (instr == I_ENCT) && aci && !done_c;

  assign ac_step = dir_down ? (ac_q - ONE) : (ac_q + ONE);

  always_comb begin
    wc_step = wc_q;
    case (mode)
      M_WC_DOWN: wc_step = wc_q - ONE;
      M_WC_UP:   wc_step = wc_q + ONE;
      M_AC_CMP:  wc_step = wc_q;
      M_FREE:    wc_step = wc_q + ONE;
      default:   wc_step = wc_q;
    endcase
  end

  // Next-state decode. Loads and ENCT are mutually exclusive by encoding,
  // so a load always wins over a step that would have happened.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    cr_d   = cr_q;
    ar_d   = ar_q;
    ac_d   = ac_q;
    wr_d   = wr_q;
    wc_d   = wc_q;
    dout_d = '0;
    oe_d   = 1'b0;

    case (instr_e'(instr))
      I_WRCR: cr_d = din[2:0];
      I_RDCR: begin
        dout_d = {{(WIDTH-3){1'b0}}, cr_q};
        oe_d   = 1'b1;
      end
      I_RDWC: begin
        dout_d = wc_q;
        oe_d   = 1'b1;
      end
      I_RDAC: begin
        dout_d = ac_q;
        oe_d   = 1'b1;
      end
      I_REINIT: begin
        ac_d = ar_q;
        // Count-up mode restarts from zero toward WR.
        wc_d = (mode == M_WC_UP) ? '0 : wr_q;
      end
      I_LDAR: begin
        ar_d = din;
        ac_d = din;
      end
      I_LDWC: begin
        wr_d = din;
        wc_d = (mode == M_WC_UP) ? '0 : din;
      end
      I_ENCT: begin
        if (step) begin
          ac_d = ac_step;
          wc_d = wc_step;
        end
      end
      default: ;
    endcase
  end

  // Reset overrides whatever instruction is presented, so a transfer in
  // flight is dropped with no residual step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      cr_q   <= '0;
      ar_q   <= '0;
      ac_q   <= '0;
      wr_q   <= '0;
      wc_q   <= '0;
      dout_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      cr_q   <= cr_d;
      ar_q   <= ar_d;
      ac_q   <= ac_d;
      wr_q   <= wr_d;
      wc_q   <= wc_d;
      dout_q <= dout_d;
      oe_q   <= oe_d;
    end
  end

  assign dout = dout_q;
  assign oe   = oe_q;
  assign addr = ac_q;
  assign done = done_c;

`ifdef DMA_CARRY_OUT_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Carries flag the step cycle whose update wraps the counter; they are
  // combinational and qualified by the same step condition as the counters.
  assign aco = step && (dir_down ? (ac_q == '0) : (ac_q == ALL_ONES));
  assign wco = step && (mode == M_FREE) && (wc_q == ALL_ONES);
`else
  assign aco = 1'b0;
  assign wco = 1'b0;
`endif

endmodule

// File: tb/tb_dma_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_dma_addr_gen -- directed self-checking bench for dma_addr_gen (WIDTH=8).
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked there, combinational carries are checked 2 units later, before
// the next edge. Carry expectations follow DMA_CARRY_OUT_EN.
// -----------------------------------------------------------------------------
module tb_dma_addr_gen;

  localparam int WIDTH = 8;

`ifdef DMA_CARRY_OUT_EN
  localparam logic CARRY_EN = 1'b1;
`else
  localparam logic CARRY_EN = 1'b0;
`endif

  localparam logic [2:0] WRCR   = 3'b000;
  localparam logic [2:0] RDCR   = 3'b001;
  localparam logic [2:0] RDWC   = 3'b010;
  localparam logic [2:0] RDAC   = 3'b011;
  localparam logic [2:0] REINIT = 3'b100;
  localparam logic [2:0] LDAR   = 3'b101;
  localparam logic [2:0] LDWC   = 3'b110;
  localparam logic [2:0] ENCT   = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       instr;
  logic [WIDTH-1:0] din;
  logic             aci;
  logic [WIDTH-1:0] dout;
  logic             oe;
  logic [WIDTH-1:0] addr;
  logic             done;
  logic             aco;
  logic             wco;

  int checks = 0;
  int errors = 0;

  // Hand-computed step sequences
  logic [7:0] e28_addr [5] = '{8'h11, 8'h12, 8'h13, 8'h13, 8'h13};
  logic       e28_done [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] e29_addr [4] = '{8'h04, 8'h03, 8'h03, 8'h03};
  logic       e29_done [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] e30_addr [4] = '{8'hFF, 8'h00, 8'h01, 8'h01};
  logic       e30_done [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       e30_aco  [4] = '{1'b0, CARRY_EN, 1'b0, 1'b0};

  always #5 clk = ~clk;

  dma_addr_gen #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .instr (instr),
    .din   (din),
    .aci   (aci),
    .dout  (dout),
    .oe    (oe),
    .addr  (addr),
    .done  (done),
    .aco   (aco),
    .wco   (wco)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] i, input logic [7:0] d, input logic a);
    instr = i;
    din   = d;
    aci   = a;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] i, input logic [7:0] d, input logic a);
    drive(i, d, a);
    tick();
  endtask

  task automatic rd(input logic [2:0] i, input string tag, input logic [7:0] exp);
    op(i, 8'h00, 1'b0);
    check(tag, 32'(dout), 32'(exp));
    check({tag, "_oe"}, 32'(oe), 32'h1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset overrides a load presented at the same time
    rst = 1'b1; instr = LDAR; din = 8'h55; aci = 1'b1;
    tick();
    tick();
    check("rst_addr", 32'(addr), 32'h00);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_oe",   32'(oe),   32'h0);
    check("rst_done", 32'(done), 32'h1);
    check("rst_aco",  32'(aco),  32'h0);
    check("rst_wco",  32'(wco),  32'h0);
    rst = 1'b0;

    // Read CR after reset
    rd(RDCR, "rdcr_rst", 8'h00);
    check("rdcr_rst_done", 32'(done), 32'h1);

    // Mode 00, increment, WC counts 3 -> 0
    op(WRCR, 8'h00, 1'b0);
    check("wrcr_oe",   32'(oe),   32'h0);
    check("wrcr_dout", 32'(dout), 32'h00);
    op(LDAR, 8'h10, 1'b0);
    check("ldar_addr", 32'(addr), 32'h10);
    op(LDWC, 8'h03, 1'b0);
    check("ldwc_done", 32'(done), 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(ENCT, 8'h00, 1'b1);
      check($sformatf("m00_aco%0d", k), 32'(aco), 32'h0);
      tick();
      check($sformatf("m00_addr%0d", k), 32'(addr), 32'(e28_addr[k]));
      check($sformatf("m00_done%0d", k), 32'(done), 32'(e28_done[k]));
    end
    rd(RDWC, "m00_wc_end", 8'h00);

    // Two steps, then REINIT and an ENCT with aci=0
    op(LDAR, 8'h10, 1'b0);
    op(LDWC, 8'h03, 1'b0);
    op(ENCT, 8'h00, 1'b1);
    op(ENCT, 8'h00, 1'b1);
    check("pre_reinit_addr", 32'(addr), 32'h12);
    rd(RDWC, "pre_reinit_wc", 8'h01);
    op(REINIT, 8'h00, 1'b0);
    check("reinit_addr", 32'(addr), 32'h10);
    check("reinit_done", 32'(done), 32'h0);
    rd(RDWC, "reinit_wc", 8'h03);
    op(ENCT, 8'h00, 1'b0);
    check("aci0_addr", 32'(addr), 32'h10);
    rd(RDWC, "aci0_wc", 8'h03);

    // Mode change leaves counters alone; done follows the new mode
    op(WRCR, 8'h02, 1'b0);
    check("mode10_done", 32'(done), 32'h0);
    op(WRCR, 8'h01, 1'b0);
    check("mode01_done", 32'(done), 32'h1);
    check("mode01_addr", 32'(addr), 32'h10);
    rd(RDWC, "mode01_wc", 8'h03);
    rd(RDCR, "mode01_cr", 8'h01);

    // Reset in the middle of a transfer
    op(WRCR, 8'h00, 1'b0);
    op(LDAR, 8'h10, 1'b0);
    op(LDWC, 8'h03, 1'b0);
    op(ENCT, 8'h00, 1'b1);
    op(ENCT, 8'h00, 1'b1);
    check("midrst_pre_addr", 32'(addr), 32'h12);
    rst = 1'b1;
    op(ENCT, 8'h00, 1'b1);
    rst = 1'b0;
    check("midrst_addr", 32'(addr), 32'h00);
    check("midrst_done", 32'(done), 32'h1);
    rd(RDCR, "midrst_cr", 8'h00);
    rd(RDAC, "midrst_ac", 8'h00);
    rd(RDWC, "midrst_wc", 8'h00);

    // Mode 01, decrement: WC counts 0 -> WR
    op(WRCR, 8'h05, 1'b0);
    op(LDAR, 8'h05, 1'b0);
    op(LDWC, 8'h02, 1'b0);
    check("m01_load_done", 32'(done), 32'h0);
    rd(RDWC, "m01_load_wc", 8'h00);
    for (int k = 0; k < 4; k++) begin
      op(ENCT, 8'h00, 1'b1);
      check($sformatf("m01_addr%0d", k), 32'(addr), 32'(e29_addr[k]));
      check($sformatf("m01_done%0d", k), 32'(done), 32'(e29_done[k]));
    end
    rd(RDWC, "m01_wc_end", 8'h02);

    // Mode 10, increment across the wrap, stop at AC == WR
    op(WRCR, 8'h02, 1'b0);
    op(LDAR, 8'hFE, 1'b0);
    op(LDWC, 8'h01, 1'b0);
    check("m10_load_done", 32'(done), 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(ENCT, 8'h00, 1'b1);
      check($sformatf("m10_aco%0d", k), 32'(aco), 32'(e30_aco[k]));
      tick();
      check($sformatf("m10_addr%0d", k), 32'(addr), 32'(e30_addr[k]));
      check($sformatf("m10_done%0d", k), 32'(done), 32'(e30_done[k]));
    end

    // Mode 10, decrement across the wrap
    op(WRCR, 8'h06, 1'b0);
    op(LDAR, 8'h01, 1'b0);
    op(LDWC, 8'h80, 1'b0);
    drive(ENCT, 8'h00, 1'b1);
    check("dec_aco0", 32'(aco), 32'h0);
    tick();
    check("dec_addr0", 32'(addr), 32'h00);
    drive(ENCT, 8'h00, 1'b1);
    check("dec_aco1", 32'(aco), 32'(CARRY_EN));
    tick();
    check("dec_addr1", 32'(addr), 32'hFF);
    check("dec_done", 32'(done), 32'h0);

    // Mode 11: WC wraps, carry gated by aci, done never asserts
    op(WRCR, 8'h03, 1'b0);
    op(LDWC, 8'hFF, 1'b0);
    check("m11_done", 32'(done), 32'h0);
    drive(ENCT, 8'h00, 1'b0);
    check("m11_wco_gated", 32'(wco), 32'h0);
    check("m11_aco_gated", 32'(aco), 32'h0);
    tick();
    drive(ENCT, 8'h00, 1'b1);
    check("m11_wco", 32'(wco), 32'(CARRY_EN));
    check("m11_aco", 32'(aco), 32'(CARRY_EN));
    tick();
    check("m11_addr", 32'(addr), 32'h00);
    check("m11_done_after", 32'(done), 32'h0);
    rd(RDWC, "m11_wc", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_addr_gen.md
DMA_ADDR_GEN -- requirements
Module: dma_addr_gen

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the address, word and data paths; legal range 4..32.
REQ-002 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port instr, input, 3 bits: instruction, sampled every cycle.
REQ-005 Port din, input, WIDTH bits: load data for the control, address and word registers.
REQ-006 Port aci, input, 1 bit: count enable, used only with the ENCT instruction.
REQ-007 Port dout, output, WIDTH bits: registered read-back data.
REQ-008 Port oe, output, 1 bit: registered marker that dout holds valid data.
REQ-009 Port addr, output, WIDTH bits: current address counter (AC).
REQ-010 Port done, output, 1 bit: terminal condition, combinational from registers.
REQ-011 Port aco, output, 1 bit: address-counter carry/borrow.
REQ-012 Port wco, output, 1 bit: word-counter carry.

Function
REQ-013 The block SHALL hold these state registers: CR[2:0], AR, AC, WR and WC, each WIDTH bits except CR.
- CR[1:0] selects the mode.
- CR[2] selects the address direction: 0 = increment, 1 = decrement.
REQ-014 The instructions SHALL be:
- 000 WRCR: CR<=din[2:0].
- 001 RDCR: dout<={0..0,CR}.
- 010 RDWC: dout<=WC.
- 011 RDAC: dout<=AC.
- 100 REINIT: AC<=AR; WC<=0 in mode 01, otherwise WC<=WR.
- 101 LDAR: AR<=din; AC<=din.
- 110 LDWC: WR<=din; WC<=0 in mode 01, otherwise WC<=din.
- 111 ENCT: count step.
REQ-015 Read instructions (001/010/011) SHALL set oe=1 and dout one cycle after instr is presented; any other instruction SHALL give oe=0 and dout=0 on the next cycle.
REQ-016 A step SHALL occur only when instr=111, aci=1 and done=0.
- Otherwise AC and WC hold.
- Instructions 000-110 never step.
REQ-017 On a step, AC SHALL move by one in the CR[2] direction, wrapping modulo 2^WIDTH.
REQ-018 On a step, WC SHALL move by mode:
- 00: decrement.
- 01: increment.
- 10: hold.
- 11: increment, wrapping.
REQ-019 done SHALL be asserted by mode:
- 00: when WC==0.
- 01: when WC==WR.
- 10: when AC==WR.
- 11: never.
REQ-020 done SHALL go high in the same cycle as the register update that meets the condition; once done is high, stepping SHALL stop with no overshoot.
REQ-021 A WRCR that changes mode SHALL NOT modify AC, WC or WR; done SHALL re-evaluate immediately under the new mode.
REQ-022 A load or REINIT on the same edge as the condition being met SHALL take priority, because load instructions and ENCT are mutually exclusive per cycle.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL clear CR, AR, AC, WR, WC, dout and oe to 0, overriding any instruction presented in that cycle.
REQ-024 After reset, done SHALL read 1 (mode 00 with WC=0), and aco and wco SHALL read 0.
REQ-025 A reset mid-transfer SHALL abandon the transfer with no residual step.

Configuration
REQ-026 Macro DMA_CARRY_OUT_EN SHALL control the carry outputs.
- Defined, aco: 1 in the step cycle in which AC wraps (0xFF..->0 when incrementing, 0->all-ones when decrementing).
- Defined, wco: 1 in the step cycle in which WC wraps in mode 11.
- Both carries are combinational and gated by the step condition.
- Not defined: aco and wco are tied to 0 and no carry logic is generated.

Verification (WIDTH=8)
REQ-027 Reset, then RDCR -> one cycle later dout=0x00 and oe=1; done=1.
REQ-028 WRCR 0x00, LDAR 0x10, LDWC 0x03, then ENCT with aci=1 for 5 cycles -> addr 0x11, 0x12, 0x13, then holds; WC 3->0; done rises on the third step.
REQ-029 WRCR 0x05, LDAR 0x05, LDWC 0x02, then ENCT for 4 cycles -> WC=0 after the load; addr 0x04, 0x03, then holds; done=1 when WC=2.
REQ-030 WRCR 0x02, LDAR 0xFE, LDWC 0x01, then ENCT -> addr 0xFF, 0x00, 0x01, then done; with DMA_CARRY_OUT_EN, aco=1 only on the 0xFF->0x00 step.
REQ-031 From the REQ-028 state after 2 steps, REINIT -> addr=0x10, WC=0x03, done=0; a following ENCT with aci=0 -> no change.
REQ-032 Assert rst during ENCT at addr 0x12 -> on the next edge addr=0x00 and CR=0; RDAC then returns 0x00.
